// File: rtl/rpll_cfg_sequencer.sv
// rPLL bring-up and reconfiguration sequencer, clocked from the PLL reference clock.
// Drives RESET and the dynamic divider selects, qualifies LOCK, and reports clk_ok / lock loss.
module rpll_cfg_sequencer #(
    parameter logic [5:0]  DEF_IDSEL     = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL    = 6'd0,
    parameter logic [5:0]  DEF_ODSEL     = 6'd0,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clk_ok,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       lock_lost,
    output logic [7:0] relock_count
);

    // cfg handshake: a divider set transfers on a cycle where cfg_valid && cfg_ready;
    // cfg_ready is only high in RUN and FAIL, and cfg_* is ignored otherwise.

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [23:0] RST_LAST  = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] TO_LAST   = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] STB_LAST  = 24'(STABLE_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [23:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic        sync1_q, lock_sync_q;
    logic        pll_reset_q, pll_reset_d;
    logic [5:0]  idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic        clk_ok_q, clk_ok_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        lock_lost_q, lock_lost_d;
    logic [7:0]  relock_q, relock_d;
    logic        accept;

    assign accept = cfg_valid && cfg_ready_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        idsel_d     = idsel_q;
        fbdsel_d    = fbdsel_q;
        odsel_d     = odsel_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        lock_lost_d = 1'b0;
        relock_d    = relock_q;

        case (state_q)
            ST_RST: begin
                timer_d = timer_q + 24'd1;
                if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                timer_d = timer_q + 24'd1;
                if (lock_sync_q) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_RST;
                    end else begin
                        state_d = ST_FAIL;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                timer_d = timer_q + 24'd1;
                if (!lock_sync_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == STB_LAST) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // A simultaneous cfg offer outranks the lock drop: the reset it triggers
                // re-acquires lock anyway, so the loss is not reported.
                if (accept) begin
                    idsel_d  = cfg_idsel;
                    fbdsel_d = cfg_fbdsel;
                    odsel_d  = cfg_odsel;
                    retry_d  = 8'd0;
                    state_d  = ST_RST;
                end else if (!lock_sync_q) begin
                    lock_lost_d = 1'b1;
                    relock_d    = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    retry_d     = 8'd0;
                    state_d     = ST_WAIT_LOCK;
                end
            end
            ST_FAIL: begin
                if (accept) begin
                    idsel_d  = cfg_idsel;
                    fbdsel_d = cfg_fbdsel;
                    odsel_d  = cfg_odsel;
                    retry_d  = 8'd0;
                    state_d  = ST_RST;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (state_d != state_q) timer_d = 24'd0;

        // Level outputs follow the next state so they register in step with it.
        pll_reset_d = (state_d == ST_RST);
        clk_ok_d    = (state_d == ST_RUN);
        cfg_ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
        busy_d      = (state_d == ST_RST) || (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            timer_q     <= 24'd0;
            retry_q     <= 8'd0;
            sync1_q     <= 1'b0;
            lock_sync_q <= 1'b0;
            pll_reset_q <= 1'b1;
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
            clk_ok_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lock_lost_q <= 1'b0;
            relock_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            sync1_q     <= pll_lock;
            lock_sync_q <= sync1_q;
            pll_reset_q <= pll_reset_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            clk_ok_q    <= clk_ok_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lock_lost_q <= lock_lost_d;
            relock_q    <= relock_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign pll_reset    = pll_reset_q;
    assign pll_idsel    = idsel_q;
    assign pll_fbdsel   = fbdsel_q;
    assign pll_odsel    = odsel_q;
    assign clk_ok       = clk_ok_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign lock_lost    = lock_lost_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_rpll_cfg_sequencer.sv
// Directed-random bench for rpll_cfg_sequencer: boot, reconfig, glitch, lock loss,
// collision, timeout/FAIL and asynchronous reset, checked against a behavioural model.
module tb_rpll_cfg_sequencer;

  localparam int RC = 16;
  localparam int LT = 150;
  localparam int SC = 32;
  localparam int MR = 3;
  localparam logic [5:0] DEF_ID = 6'd1;
  localparam logic [5:0] DEF_FB = 6'd10;
  localparam logic [5:0] DEF_OD = 6'd4;
  // Edges from driving pll_lock high to clk_ok: 1 input sample, 2 sync flops, STABLE_CYCLES.
  localparam int LOCK_TO_OK = SC + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [5:0] cfg_idsel = '0;
  logic [5:0] cfg_fbdsel = '0;
  logic [5:0] cfg_odsel = '0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       clk_ok, busy, done, err, lock_lost;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: divider set the PLL should currently see, saturating lock-loss count.
  logic [17:0] model_sel = {DEF_ID, DEF_FB, DEF_OD};
  int          model_relock = 0;
  logic [17:0] exp_q[$];

  // Event counters sampled away from the active edge.
  int  done_cnt = 0, err_cnt = 0, lost_cnt = 0, rst_rise = 0, loss_rst = 0;
  logic prev_rst = 1'b0;
  logic loss_phase = 1'b0;

  rpll_cfg_sequencer #(
    .DEF_IDSEL(DEF_ID), .DEF_FBDSEL(DEF_FB), .DEF_ODSEL(DEF_OD),
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .clk_ok(clk_ok), .busy(busy), .done(done), .err(err),
    .lock_lost(lock_lost), .relock_count(relock_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (lock_lost) lost_cnt++;
      if (pll_reset && !prev_rst) rst_rise++;
      if (loss_phase && pll_reset) loss_rst++;
    end
    prev_rst = pll_reset;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return clk_ok;
      1: return pll_reset;
      default: return err;
    endcase
  endfunction

  task automatic wait_level(input string tag, input int which, input logic lvl,
                            input int budget, output int n);
    n = 0;
    while (sig(which) !== lvl && n < budget) begin
      tick(1);
      n++;
    end
    if (sig(which) !== lvl) check({tag, "_timeout"}, 32'(sig(which)), 32'(lvl));
  endtask

  task automatic check_sel(input string tag, input logic [17:0] exp);
    check({tag, "_sel"}, 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'(exp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_reset"}, 32'(pll_reset), 1);
    check_sel(tag, {DEF_ID, DEF_FB, DEF_OD});
    check({tag, "_clk_ok"}, 32'(clk_ok), 0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_pulses"}, 32'({done, err, lock_lost}), 0);
    check({tag, "_relock"}, 32'(relock_count), 0);
  endtask

  // Offer a divider set while the sequencer is known to be ready; a real PLL drops lock in reset.
  task automatic send_cfg(input string tag, input logic [5:0] id, input logic [5:0] fb,
                          input logic [5:0] od);
    cfg_idsel = id; cfg_fbdsel = fb; cfg_odsel = od;
    cfg_valid = 1'b1;
    pll_lock  = 1'b0;
    model_sel = {id, fb, od};
    exp_q.push_back(model_sel);
    tick(1);
    cfg_valid = 1'b0;
    check({tag, "_reset_hi"}, 32'(pll_reset), 1);
    check({tag, "_clk_ok_lo"}, 32'(clk_ok), 0);
    check({tag, "_busy"}, 32'(busy), 1);
    check_sel(tag, exp_q.pop_front());
  endtask

  // Wait for RESET to fall, hold lock low for `delay` cycles, raise it and time clk_ok.
  task automatic bring_up(input string tag, input int delay);
    int n;
    int d0;
    wait_level({tag, "_rst_fall"}, 1, 1'b0, RC + 10, n);
    tick(delay);
    d0 = done_cnt;
    pll_lock = 1'b1;
    wait_level({tag, "_ok"}, 0, 1'b1, LOCK_TO_OK + 20, n);
    check({tag, "_lat"}, n, LOCK_TO_OK);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_ready"}, 32'(cfg_ready), 1);
    check({tag, "_busy_lo"}, 32'(busy), 0);
    check_sel(tag, model_sel);
    tick(1);
    check({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  // stimulus
  initial begin
    int n;
    int r0, e0, l0, d0;
    logic [5:0] a, b, c;

    // 1 boot
    tick(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    wait_level("boot_rst", 1, 1'b0, RC + 10, n);
    check("boot_reset_len", n, RC);
    bring_up("boot", $urandom_range(20, 120));

    // 2 reconfig: fixed set, then random sets; cfg ignored while not ready
    send_cfg("cfg0", 6'd3, 6'd24, 6'd8);
    cfg_idsel = 6'd63; cfg_fbdsel = 6'd63; cfg_odsel = 6'd63; cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    check_sel("ignored", model_sel);
    check("ignored_reset", 32'(pll_reset), 1);
    bring_up("cfg0", 100);
    for (int i = 0; i < 3; i++) begin
      a = 6'($urandom); b = 6'($urandom); c = 6'($urandom);
      send_cfg("cfg_rnd", a, b, c);
      bring_up("cfg_rnd", $urandom_range(5, 120));
    end

    // 4 glitch in STABLE: no clk_ok, stable count restarts after lock returns
    send_cfg("glitch", 6'($urandom), 6'($urandom), 6'($urandom));
    wait_level("glitch_rst", 1, 1'b0, RC + 10, n);
    tick($urandom_range(5, 60));
    d0 = done_cnt;
    pll_lock = 1'b1;
    tick(SC - 6);
    pll_lock = 1'b0;
    tick(3);
    check("glitch_no_ok", 32'(clk_ok), 0);
    check("glitch_busy", 32'(busy), 1);
    pll_lock = 1'b1;
    wait_level("glitch_ok", 0, 1'b1, LOCK_TO_OK + 20, n);
    check("glitch_restart_lat", n, LOCK_TO_OK);
    tick(1);
    check("glitch_done_once", done_cnt - d0, 1);

    // 5 lock loss in RUN, 300 times; relock_count saturates, RESET stays low
    l0 = lost_cnt;
    loss_phase = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick($urandom_range(1, 3));
      pll_lock = 1'b1;
      wait_level("loss_drop", 0, 1'b0, 10, n);
      model_relock = (model_relock < 255) ? model_relock + 1 : 255;
      check("loss_pulse", 32'(lock_lost), 1);
      check("loss_count", 32'(relock_count), model_relock);
      wait_level("loss_relock", 0, 1'b1, LOCK_TO_OK + 20, n);
    end
    tick(1);
    loss_phase = 1'b0;
    check("loss_events", lost_cnt - l0, 300);
    check("loss_saturated", 32'(relock_count), 255);
    check("loss_no_reset", loss_rst, 0);

    // 6a collision: cfg offered in the cycle RUN sees the lock drop
    l0 = lost_cnt;
    pll_lock = 1'b0;
    tick(2);
    send_cfg("collide", 6'($urandom), 6'($urandom), 6'($urandom));
    tick(1);
    check("collide_no_lost", lost_cnt - l0, 0);
    check("collide_count", 32'(relock_count), model_relock);
    bring_up("collide", $urandom_range(5, 60));

    // 3 timeout: lock never returns -> MR+1 reset pulses then one err pulse, FAIL holds
    r0 = rst_rise;
    e0 = err_cnt;
    send_cfg("tmo", 6'($urandom), 6'($urandom), 6'($urandom));
    wait_level("tmo_err", 2, 1'b1, (MR + 1) * (RC + LT) + 50, n);
    tick(1);
    check("tmo_reset_pulses", rst_rise - r0, MR + 1);
    check("tmo_err_once", err_cnt - e0, 1);
    check("tmo_err_lo", 32'(err), 0);
    tick(30);
    check("fail_ready", 32'(cfg_ready), 1);
    check("fail_clk_ok", 32'(clk_ok), 0);
    check("fail_reset_lo", 32'(pll_reset), 0);
    check("fail_busy_lo", 32'(busy), 0);
    check_sel("fail", model_sel);
    send_cfg("fail_cfg", 6'($urandom), 6'($urandom), 6'($urandom));
    bring_up("fail_cfg", $urandom_range(5, 60));

    // 6b asynchronous reset during WAIT_LOCK
    send_cfg("arst", 6'($urandom), 6'($urandom), 6'($urandom));
    wait_level("arst_rst", 1, 1'b0, RC + 10, n);
    tick(10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    model_sel = {DEF_ID, DEF_FB, DEF_OD};
    model_relock = 0;
    tick(2);
    rst_n = 1'b1;
    wait_level("arst_rel", 1, 1'b0, RC + 10, n);
    check("arst_reset_len", n, RC);
    bring_up("arst", $urandom_range(5, 60));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
